// File: rtl/jtag_dr_sequencer.sv
// USER data-register sequencer behind a BSCANE2 TAP: deserialises TDI words into an rx FIFO
// and serialises a {result, valid} word onto TDO during the same DR scan, all in the tck domain.
module jtag_dr_sequencer #(
   parameter int DATA_W     = 8,
   parameter int RESULT_W   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                tck,
   input  logic                rst_n,
   input  logic                test_logic_reset,
   input  logic                ir_is_user,
   input  logic                capture_dr,
   input  logic                shift_dr,
   input  logic                update_dr,
   input  logic                tdi,
   output logic                tdo,
   output logic [DATA_W-1:0]   rx_data,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic                frame_end,
   input  logic [RESULT_W-1:0] result_data,
   input  logic                result_valid,
   output logic                overflow,
   output logic                partial
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TX_W  = RESULT_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOADED = 2'd1,
      ST_SHIFT  = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [CNT_W-1:0]    bit_cnt_r;
   logic [DATA_W-1:0]   rx_sr_r;
   logic [TX_W-1:0]     tx_sr_r;
   logic                frame_end_r, overflow_r, partial_r;
   logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr_r, rd_ptr_r;

   logic                cap_q_s, shift_q_s, upd_q_s;
   logic                load_s, shift_en_s, end_frame_s, push_s, pop_s, push_ok_s;
   logic                empty_s, full_s;
   logic [DATA_W-1:0]   rx_word_s;

   assign cap_q_s   = ir_is_user & capture_dr;
   assign shift_q_s = ir_is_user & shift_dr;
   assign upd_q_s   = ir_is_user & update_dr;
   assign rx_word_s = {tdi, rx_sr_r[DATA_W-1:1]};

   // FSM state register
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and frame strobes; capture restarts the frame from any state
   always_comb begin
      state_s     = state_r;
      load_s      = 1'b0;
      shift_en_s  = 1'b0;
      end_frame_s = 1'b0;
      if (test_logic_reset) begin
         state_s = ST_IDLE;
      end else if (cap_q_s) begin
         state_s = ST_LOADED;
         load_s  = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_LOADED, ST_SHIFT: begin
               if (upd_q_s) begin
                  state_s     = ST_IDLE;
                  end_frame_s = 1'b1;
               end else if (shift_q_s) begin
                  state_s    = ST_SHIFT;
                  shift_en_s = 1'b1;
               end else begin
                  state_s = state_r;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   assign push_s    = shift_en_s & (bit_cnt_r == CNT_LAST);
   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                      (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
   assign pop_s     = ~empty_s & rx_ready;
   // A pop in the same cycle frees the slot a push into a full FIFO needs
   assign push_ok_s = push_s & (~full_s | pop_s);

   // Shift registers, bit counter and sticky flags
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r   <= {CNT_W{1'b0}};
         rx_sr_r     <= {DATA_W{1'b0}};
         tx_sr_r     <= {TX_W{1'b0}};
         frame_end_r <= 1'b0;
         partial_r   <= 1'b0;
         overflow_r  <= 1'b0;
      end else if (test_logic_reset) begin
         bit_cnt_r   <= {CNT_W{1'b0}};
         rx_sr_r     <= {DATA_W{1'b0}};
         tx_sr_r     <= {TX_W{1'b0}};
         frame_end_r <= 1'b0;
         partial_r   <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         frame_end_r <= end_frame_s;
         if (push_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end
         if (load_s) begin
            tx_sr_r   <= {result_data, result_valid};
            bit_cnt_r <= {CNT_W{1'b0}};
         end else if (end_frame_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            if (bit_cnt_r != {CNT_W{1'b0}}) begin
               partial_r <= 1'b1;
            end
         end else if (shift_en_s) begin
            rx_sr_r   <= rx_word_s;
            tx_sr_r   <= {1'b0, tx_sr_r[TX_W-1:1]};
            bit_cnt_r <= push_s ? {CNT_W{1'b0}} : bit_cnt_r + CNT_W'(1);
         end
      end
   end

   // FIFO pointers; test_logic_reset flushes the queue
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {(PTR_W+1){1'b0}};
         rd_ptr_r <= {(PTR_W+1){1'b0}};
      end else if (test_logic_reset) begin
         wr_ptr_r <= {(PTR_W+1){1'b0}};
         rd_ptr_r <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
         end
      end
   end

   // FIFO storage; contents are only visible through the registered pointers
   always_ff @(posedge tck) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[PTR_W-1:0]] <= rx_word_s;
      end
   end

   assign tdo       = tx_sr_r[0];
   assign rx_valid  = ~empty_s;
   assign rx_data   = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r[PTR_W-1:0]];
   assign frame_end = frame_end_r;
   assign overflow  = overflow_r;
   assign partial   = partial_r;

endmodule

// File: tb/tb_jtag_dr_sequencer.sv
// Directed bench for jtag_dr_sequencer: a per-cycle vector table for the tdo/capture path,
// then hand-written frames for the FIFO, overflow, partial-word and reset corner cases.
module tb_jtag_dr_sequencer;

   logic        tck = 1'b0;
   logic        rst_n, test_logic_reset, ir_is_user, capture_dr, shift_dr, update_dr, tdi;
   logic        tdo, rx_valid, rx_ready, frame_end, result_valid, overflow, partial;
   logic [7:0]  rx_data;
   logic [15:0] result_data;

   int          n_chk = 0;
   int          n_fail = 0;
   int          fe_cnt = 0;
   logic [7:0]  popq[$];

   jtag_dr_sequencer #(.DATA_W(8), .RESULT_W(16), .FIFO_DEPTH(4)) dut (
      .tck(tck), .rst_n(rst_n), .test_logic_reset(test_logic_reset), .ir_is_user(ir_is_user),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr), .tdi(tdi),
      .tdo(tdo), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_end(frame_end), .result_data(result_data), .result_valid(result_valid),
      .overflow(overflow), .partial(partial)
   );

   always #5 tck = ~tck;

   typedef struct {
      string      name;
      logic       tlr, ir, cap, sh, upd, tdi;
      logic       e_tdo, e_valid;
      logic [7:0] e_data;
      logic       e_fe, e_ovf, e_part;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string nm, logic tlr, logic ir, logic cap, logic sh, logic upd,
                               logic ti, logic e_tdo, logic e_valid, logic [7:0] e_data,
                               logic e_fe, logic e_ovf, logic e_part);
      vec_t v;
      v.name = nm; v.tlr = tlr; v.ir = ir; v.cap = cap; v.sh = sh; v.upd = upd; v.tdi = ti;
      v.e_tdo = e_tdo; v.e_valid = e_valid; v.e_data = e_data;
      v.e_fe = e_fe; v.e_ovf = e_ovf; v.e_part = e_part;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_word(input string name, input int idx, input logic [7:0] exp);
      chk(name, (idx < popq.size()) ? {24'h0, popq[idx]} : 32'hDEAD, {24'h0, exp});
   endtask

   // One tck cycle; records handshakes and frame_end pulses, returns #1 after the edge
   task automatic tick();
      logic       pre_pop;
      logic [7:0] pre_data;
      pre_pop  = rx_valid & rx_ready;
      pre_data = rx_data;
      @(posedge tck);
      #1;
      if (pre_pop) popq.push_back(pre_data);
      if (frame_end) fe_cnt++;
   endtask

   task automatic do_capture();
      ir_is_user = 1'b1; capture_dr = 1'b1; tick(); capture_dr = 1'b0;
   endtask

   task automatic do_update();
      ir_is_user = 1'b1; update_dr = 1'b1; tick(); update_dr = 1'b0;
   endtask

   task automatic do_tlr();
      test_logic_reset = 1'b1; tick(); test_logic_reset = 1'b0;
      popq.delete(); fe_cnt = 0;
   endtask

   task automatic shift_bits(input logic [63:0] val, input int n);
      ir_is_user = 1'b1;
      for (int i = 0; i < n; i++) begin
         shift_dr = 1'b1; tdi = val[i]; tick();
      end
      shift_dr = 1'b0; tdi = 1'b0;
   endtask

   initial begin
      logic [16:0] txv;
      vec_t        v;
      txv = {16'h1234, 1'b1};

      rst_n = 1'b0; test_logic_reset = 1'b0; ir_is_user = 1'b0; capture_dr = 1'b0;
      shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0; rx_ready = 1'b1;
      result_data = 16'h1234; result_valid = 1'b1;

      // Table: gating rules, tdo serialisation of {0x1234,1}, all-ones words, partial frame
      vecs.push_back(mk("idle",       0,0,0,0,0,0, 0,0,8'h00, 0,0,0));
      vecs.push_back(mk("cap_unqual", 0,0,1,0,0,0, 0,0,8'h00, 0,0,0));
      vecs.push_back(mk("shift_idle", 0,1,0,1,0,1, 0,0,8'h00, 0,0,0));
      vecs.push_back(mk("capture",    0,1,1,0,0,0, 1,0,8'h00, 0,0,0));
      for (int k = 1; k <= 17; k++) begin
         logic w;
         w = (k == 8) || (k == 16);
         vecs.push_back(mk($sformatf("shift%0d", k), 0,1,0,1,0,1,
                           (k <= 16) ? txv[k] : 1'b0, w, w ? 8'hFF : 8'h00, 0,0,0));
      end
      vecs.push_back(mk("update",      0,1,0,0,1,0, 0,0,8'h00, 1,0,1));
      vecs.push_back(mk("post_update", 0,0,0,0,0,0, 0,0,8'h00, 0,0,1));
      vecs.push_back(mk("tlr",         1,0,0,0,0,0, 0,0,8'h00, 0,0,0));

      // Reset state
      tick(); tick();
      chk("rst_tdo", {31'h0, tdo}, 32'h0);
      chk("rst_valid", {31'h0, rx_valid}, 32'h0);
      chk("rst_data", {24'h0, rx_data}, 32'h0);
      chk("rst_flags", {29'h0, frame_end, overflow, partial}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         test_logic_reset = v.tlr; ir_is_user = v.ir; capture_dr = v.cap;
         shift_dr = v.sh; update_dr = v.upd; tdi = v.tdi;
         tick();
         chk({v.name, "/tdo"},       {31'h0, tdo},       {31'h0, v.e_tdo});
         chk({v.name, "/rx_valid"},  {31'h0, rx_valid},  {31'h0, v.e_valid});
         chk({v.name, "/rx_data"},   {24'h0, rx_data},   {24'h0, v.e_data});
         chk({v.name, "/frame_end"}, {31'h0, frame_end}, {31'h0, v.e_fe});
         chk({v.name, "/overflow"},  {31'h0, overflow},  {31'h0, v.e_ovf});
         chk({v.name, "/partial"},   {31'h0, partial},   {31'h0, v.e_part});
      end
      test_logic_reset = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;

      // Two words 0xA5, 0x3C in one 16-bit frame
      do_tlr(); rx_ready = 1'b1;
      do_capture(); shift_bits(64'h3CA5, 16); do_update(); tick(); tick();
      chk("t1_nwords", popq.size(), 2);
      chk_word("t1_w0", 0, 8'hA5);
      chk_word("t1_w1", 1, 8'h3C);
      chk("t1_frame_end_cnt", fe_cnt, 1);
      chk("t1_partial", {31'h0, partial}, 32'h0);

      // Five words into a depth-4 FIFO with no consumer
      do_tlr(); rx_ready = 1'b0;
      do_capture(); shift_bits(64'h04030201, 32);
      chk("ovf_full_no_flag", {31'h0, overflow}, 32'h0);
      chk("ovf_head", {24'h0, rx_data}, 32'h01);
      shift_bits(64'h05, 8);
      chk("ovf_flag", {31'h0, overflow}, 32'h1);
      do_update(); rx_ready = 1'b1;
      repeat (6) tick();
      rx_ready = 1'b0;
      chk("ovf_nwords", popq.size(), 4);
      for (int i = 0; i < 4; i++) chk_word($sformatf("ovf_w%0d", i), i, 8'(i + 1));
      chk("ovf_drained", {31'h0, rx_valid}, 32'h0);

      // Full FIFO, fifth word completes on the same edge as a pop
      do_tlr(); rx_ready = 1'b0;
      do_capture(); shift_bits(64'h44332211, 32); shift_bits(64'h55, 7);
      chk("simul_pre_ovf", {31'h0, overflow}, 32'h0);
      rx_ready = 1'b1;
      shift_bits(64'h0, 1);  // bit 7 of 0x55
      chk("simul_ovf", {31'h0, overflow}, 32'h0);
      chk("simul_head", {24'h0, rx_data}, 32'h22);
      do_update(); repeat (5) tick();
      rx_ready = 1'b0;
      chk("simul_nwords", popq.size(), 5);
      for (int i = 0; i < 5; i++) chk_word($sformatf("simul_w%0d", i), i, 8'(8'h11 * (i + 1)));
      chk("simul_ovf_end", {31'h0, overflow}, 32'h0);

      // 12-bit frame: one word, partial set; next frame realigned at bit 0
      do_tlr(); rx_ready = 1'b1;
      do_capture(); shift_bits(64'hABC, 12); do_update(); tick();
      chk("part_nwords", popq.size(), 1);
      chk_word("part_w0", 0, 8'hBC);
      chk("part_flag", {31'h0, partial}, 32'h1);
      chk("part_fe_cnt", fe_cnt, 1);
      do_capture(); shift_bits(64'h5A, 8); do_update(); tick();
      chk("part_next_nwords", popq.size(), 2);
      chk_word("part_next_w1", 1, 8'h5A);
      chk("part_sticky", {31'h0, partial}, 32'h1);
      chk("part_fe_cnt2", fe_cnt, 2);

      // test_logic_reset mid-frame with 2 words queued and overflow set, colliding with shift
      do_tlr(); rx_ready = 1'b0;
      do_capture(); shift_bits(64'h0504030201, 40);
      chk("tlr_pre_ovf", {31'h0, overflow}, 32'h1);
      rx_ready = 1'b1; tick(); tick(); rx_ready = 1'b0;
      chk("tlr_pre_head", {24'h0, rx_data}, 32'h03);
      shift_bits(64'h7, 3);
      test_logic_reset = 1'b1; ir_is_user = 1'b1; shift_dr = 1'b1; tdi = 1'b1;
      tick();
      test_logic_reset = 1'b0; shift_dr = 1'b0; tdi = 1'b0;
      chk("tlr_valid", {31'h0, rx_valid}, 32'h0);
      chk("tlr_data", {24'h0, rx_data}, 32'h0);
      chk("tlr_flags", {30'h0, overflow, partial}, 32'h0);
      chk("tlr_tdo", {31'h0, tdo}, 32'h0);
      fe_cnt = 0;
      shift_bits(64'hFF, 8); tick();
      chk("tlr_noshift_valid", {31'h0, rx_valid}, 32'h0);
      do_update(); tick();
      chk("tlr_idle_update_fe", fe_cnt, 0);

      // rst_n mid-shift aborts without partial or frame_end
      do_tlr(); rx_ready = 1'b0; result_data = 16'h0000; result_valid = 1'b1;
      do_capture(); shift_bits(64'h5, 3);
      fe_cnt = 0; rst_n = 1'b0; tick(); tick();
      chk("arst_tdo", {31'h0, tdo}, 32'h0);
      rst_n = 1'b1; tick();
      chk("arst_fe_cnt", fe_cnt, 0);
      chk("arst_flags", {30'h0, overflow, partial}, 32'h0);
      chk("arst_valid", {31'h0, rx_valid}, 32'h0);
      do_capture(); shift_bits(64'h96, 8);
      chk("arst_realign", {24'h0, rx_data}, 32'h96);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
